branch_predict_local_param: RTL and testbench

- Parameterised two-level local branch predictor for the 5-stage MIPS pipeline.
- Per-PC history table (BHT) indexes a table of saturating counters (PHT).
- Predicts in F, registers the result into D, and trains from the M-stage outcome.
- Generalises history length, counter width and PHT index mode; updates the PHT only on real branches.

---
 rtl/branch_predict_local_param_if.sv | 31 +++
 rtl/branch_predict_local_param.sv | 88 ++++++++
 tb/tb_branch_predict_local_param.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/branch_predict_local_param_if.sv
// Pipeline <-> local branch predictor bus.
//   master : pipeline side (drives fetch/decode/memory-stage info, receives prediction)
//   slave  : predictor side
// Signals: stallD, flushD, pcF, branchD, pred_takeD, pcM, branchM, actual_takeM.
// With BP_PERF_CNT_EN defined the bus also carries pred_takeM (in) and
// perf_br_cnt / perf_miss_cnt (out).
interface branch_predict_local_param_if;
    logic        stallD;
    logic        flushD;
    logic [31:0] pcF;
    logic        branchD;
    logic        pred_takeD;
    logic [31:0] pcM;
    logic        branchM;
    logic        actual_takeM;
`ifdef BP_PERF_CNT_EN
    logic        pred_takeM;
    logic [31:0] perf_br_cnt;
    logic [31:0] perf_miss_cnt;

    modport master (output stallD, flushD, pcF, branchD, pcM, branchM, actual_takeM, pred_takeM,
                    input  pred_takeD, perf_br_cnt, perf_miss_cnt);
    modport slave  (input  stallD, flushD, pcF, branchD, pcM, branchM, actual_takeM, pred_takeM,
                    output pred_takeD, perf_br_cnt, perf_miss_cnt);
`else
    modport master (output stallD, flushD, pcF, branchD, pcM, branchM, actual_takeM,
                    input  pred_takeD);
    modport slave  (input  stallD, flushD, pcF, branchD, pcM, branchM, actual_takeM,
                    output pred_takeD);
`endif
endinterface

// File: rtl/branch_predict_local_param.sv
// Two-level local branch predictor for the 5-stage MIPS pipeline.
// A per-PC history table (BHT) selects a saturating counter in the PHT.
// Prediction is read combinationally in F and registered into D; training
// happens from the resolved M-stage branch.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bp (slave) : stallD/flushD control the F->D register, pcF/branchD give the
//                fetch PC and D-stage branch flag, pred_takeD is the prediction,
//                pcM/branchM/actual_takeM train the tables.
// Optional: define BP_PERF_CNT_EN to add pred_takeM and the branch / mispredict
// performance counters.
module branch_predict_local_param #(
    parameter int BHT_DEPTH = 10,
    parameter int HIST_LEN  = 6,
    parameter int CTR_W     = 2,
    parameter int IDX_MODE  = 0
) (
    input logic clk,
    input logic rst,
    branch_predict_local_param_if.slave bp
);
    localparam int BHT_N = 1 << BHT_DEPTH;
    localparam int PHT_N = 1 << HIST_LEN;
    localparam logic [CTR_W-1:0] CTR_INIT = {1'b1, {(CTR_W-1){1'b0}}};
    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};

    logic [HIST_LEN-1:0]  bht [BHT_N];
    logic [CTR_W-1:0]     pht [PHT_N];

    logic [BHT_DEPTH-1:0] bhtIdxF, bhtIdxM;
    logic [HIST_LEN-1:0]  hF, hM, idxF, idxM;
    logic [CTR_W-1:0]     ctrM;
    logic                 predF, predReg;

    // PC bits outside the index fields are intentionally ignored.
    logic unusedPc;
    assign unusedPc = ^{bp.pcF, bp.pcM};

    assign bhtIdxF = bp.pcF[BHT_DEPTH+1:2];
    assign bhtIdxM = bp.pcM[BHT_DEPTH+1:2];
    assign hF      = bht[bhtIdxF];
    assign hM      = bht[bhtIdxM];
    assign idxF    = (IDX_MODE != 0) ? (hF ^ bp.pcF[HIST_LEN+1:2]) : hF;
    assign idxM    = (IDX_MODE != 0) ? (hM ^ bp.pcM[HIST_LEN+1:2]) : hM;
    assign ctrM    = pht[idxM];
    // F reads the pre-update table contents; no bypass from the M-stage write.
    assign predF   = pht[idxF][CTR_W-1];

    // Table training; reset discards any coincident update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_N; i++) bht[i] <= '0;
            for (int i = 0; i < PHT_N; i++) pht[i] <= CTR_INIT;
        end else if (bp.branchM) begin
            bht[bhtIdxM] <= {hM[HIST_LEN-2:0], bp.actual_takeM};
            if (bp.actual_takeM) begin
                if (ctrM != CTR_MAX) pht[idxM] <= ctrM + 1'b1;
            end else begin
                if (ctrM != '0)      pht[idxM] <= ctrM - 1'b1;
            end
        end
    end

    // F->D prediction register; flush wins over stall.
    always_ff @(posedge clk) begin
        if (rst || bp.flushD) predReg <= 1'b0;
        else if (!bp.stallD)  predReg <= predF;
    end

    assign bp.pred_takeD = bp.branchD & predReg;

`ifdef BP_PERF_CNT_EN
    logic [31:0] brCnt, missCnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            brCnt   <= '0;
            missCnt <= '0;
        end else if (bp.branchM) begin
            brCnt <= brCnt + 32'd1;
            if (bp.pred_takeM != bp.actual_takeM) missCnt <= missCnt + 32'd1;
        end
    end

    assign bp.perf_br_cnt   = brCnt;
    assign bp.perf_miss_cnt = missCnt;
`endif
endmodule

// File: tb/tb_branch_predict_local_param.sv
// Directed bench: default predictor (dutA) and an IDX_MODE=1, CTR_W=3 variant (dutB).
module tb_branch_predict_local_param;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    branch_predict_local_param_if ifA ();
    branch_predict_local_param_if ifB ();

    branch_predict_local_param dutA (.clk(clk), .rst(rst), .bp(ifA));
    branch_predict_local_param #(.IDX_MODE(1), .CTR_W(3)) dutB (.clk(clk), .rst(rst), .bp(ifB));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic        p;
        int          bad;
        logic [31:0] brBase, missBase;

        brBase = 0; missBase = 0;
        ifA.stallD = 0; ifA.flushD = 0; ifA.pcF = 0; ifA.branchD = 0;
        ifA.pcM = 0; ifA.branchM = 0; ifA.actual_takeM = 0;
        ifB.stallD = 0; ifB.flushD = 0; ifB.pcF = 0; ifB.branchD = 0;
        ifB.pcM = 0; ifB.branchM = 0; ifB.actual_takeM = 0;
`ifdef BP_PERF_CNT_EN
        ifA.pred_takeM = 0;
        ifB.pred_takeM = 0;
`endif
        rst = 1;
        tick(); tick();
        rst = 0;

        // Reset state
        ifA.branchD = 1; #1;
        chk("reset_pred", {31'd0, ifA.pred_takeD}, 32'd0);
`ifdef BP_PERF_CNT_EN
        chk("reset_brcnt", ifA.perf_br_cnt, 32'd0);
`endif

        // Weakly-taken counter after reset
        ifA.pcF = 32'h100; tick();
        chk("init_pred_taken", {31'd0, ifA.pred_takeD}, 32'd1);
        ifA.branchD = 0; #1;
        chk("init_pred_nobranch", {31'd0, ifA.pred_takeD}, 32'd0);
        ifA.branchD = 1;

        // Two not-taken updates at 0x100: history stays 0, PHT[0] 10->01->00
        ifA.pcM = 32'h100; ifA.branchM = 1; ifA.actual_takeM = 0;
        tick(); tick();
        ifA.branchM = 0;
        tick();
        chk("nt_pred", {31'd0, ifA.pred_takeD}, 32'd0);
        chk("nt_pht0", {30'd0, dutA.pht[0]}, 32'd0);
        chk("nt_bht40", {26'd0, dutA.bht[10'h040]}, 32'd0);

        // Alternating T,N,... at 0x200: fetch, then resolve with that prediction
`ifdef BP_PERF_CNT_EN
        brBase = ifA.perf_br_cnt; missBase = ifA.perf_miss_cnt;
`endif
        ifA.pcF = 32'h200; ifA.pcM = 32'h200;
        for (int k = 1; k <= 20; k++) begin
            ifA.branchM = 0;
            tick();
            p = ifA.pred_takeD;
            if (k >= 7) chk("alt_pred", {31'd0, p}, {31'd0, k[0]});
            ifA.branchM = 1; ifA.actual_takeM = k[0];
`ifdef BP_PERF_CNT_EN
            ifA.pred_takeM = p;
`endif
            tick();
        end
        ifA.branchM = 0;
`ifdef BP_PERF_CNT_EN
        ifA.pred_takeM = 0;
        chk("alt_brcnt", ifA.perf_br_cnt - brBase, 32'd20);
        chk("alt_misscnt", ifA.perf_miss_cnt - missBase, 32'd4);
`endif
        tick();
        chk("alt_after_hist2a", {31'd0, ifA.pred_takeD}, 32'd1);

        // Stall holds, flush beats stall
        ifA.stallD = 1; ifA.pcF = 32'h100;
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("stall_hold", {31'd0, ifA.pred_takeD}, 32'd1);
        end
        ifA.stallD = 0; tick();
        chk("stall_release", {31'd0, ifA.pred_takeD}, 32'd0);
        ifA.pcF = 32'h200; tick();
        chk("refetch_200", {31'd0, ifA.pred_takeD}, 32'd1);
        ifA.stallD = 1; ifA.flushD = 1; tick();
        chk("flush_over_stall", {31'd0, ifA.pred_takeD}, 32'd0);
        ifA.stallD = 0; ifA.flushD = 0;

        // Same-cycle read/update of 0x300: F sees the old counter
        ifA.pcF = 32'h300; ifA.pcM = 32'h300; ifA.branchM = 1; ifA.actual_takeM = 1;
        tick();
        chk("same_cycle_old", {31'd0, ifA.pred_takeD}, 32'd0);
        ifA.branchM = 0;
        chk("same_cycle_bht", {26'd0, dutA.bht[10'h0C0]}, 32'd1);
        ifA.pcF = 32'h100; tick();
        chk("new_pht0_visible", {31'd0, ifA.pred_takeD}, 32'd1);
        ifA.pcF = 32'h300; tick();
        chk("refetch_300", {31'd0, ifA.pred_takeD}, 32'd0);
        // Bits [1:0] and above the index range are ignored
        ifA.pcF = 32'h1103; tick();
        chk("pc_alias", {31'd0, ifA.pred_takeD}, 32'd1);

        // dutB: 12 taken updates at 0x104; index = history ^ pc[7:2]
        ifB.branchD = 1; ifB.pcM = 32'h104; ifB.branchM = 1; ifB.actual_takeM = 1;
        repeat (12) tick();
        ifB.branchM = 0;
        chk("b_sat_3e", {29'd0, dutB.pht[6'h3E]}, 32'd7);
        chk("b_pht1", {29'd0, dutB.pht[6'h01]}, 32'd5);
        chk("b_hist", {26'd0, dutB.bht[10'h041]}, 32'h3F);
`ifdef BP_PERF_CNT_EN
        chk("b_brcnt", ifB.perf_br_cnt, 32'd12);
`endif
        ifB.pcF = 32'h104; tick();
        chk("b_pred", {31'd0, ifB.pred_takeD}, 32'd1);
        ifB.branchM = 1; tick();
        chk("b_no_wrap", {29'd0, dutB.pht[6'h3E]}, 32'd7);

        // Reset mid-training with branchM high: update discarded, tables reset
        rst = 1; tick();
        rst = 0; ifB.branchM = 0;
        bad = 0;
        for (int i = 0; i < 64; i++) if (dutB.pht[i] !== 3'd4) bad++;
        chk("b_rst_pht_all4", bad, 32'd0);
        chk("b_rst_bht", {26'd0, dutB.bht[10'h041]}, 32'd0);
        chk("b_rst_pred", {31'd0, ifB.pred_takeD}, 32'd0);
`ifdef BP_PERF_CNT_EN
        chk("b_rst_brcnt", ifB.perf_br_cnt, 32'd0);
        chk("b_rst_misscnt", ifB.perf_miss_cnt, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
